// File: rtl/dm_pkg.sv
// Shared types and constants for the byte-serial data-memory access controller.
package dm_pkg;

  localparam int unsigned DEF_ADDR_W = 10;
  localparam int unsigned DEF_BEATS  = 8;
  localparam int unsigned CNT_W      = $clog2(DEF_BEATS);
  localparam int unsigned DATA_W     = 64;

  typedef logic [1:0] state_t;
  localparam state_t IDLE   = 2'd0;
  localparam state_t ACCESS = 2'd1;
  localparam state_t DRAIN  = 2'd2;
  localparam state_t DONE   = 2'd3;

  localparam logic REQ_PIPE = 1'b0;
  localparam logic REQ_LD   = 1'b1;

  function automatic logic [7:0] get_byte(input logic [DATA_W-1:0] data, input int unsigned idx);
    return data[8*idx +: 8];
  endfunction

endpackage

// File: rtl/dm_rr_arbiter.sv
// Two-way round-robin arbiter between the pipeline and the loader port.
module dm_rr_arbiter
  import dm_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req_pipe,
  input  logic req_ld,
  input  logic update,
  input  logic served,
  output logic grant_valid,
  output logic grant
);

  logic last_q;

  // Last-served starts at the loader so the pipeline wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= REQ_LD;
    end else if (update) begin
      last_q <= served;
    end
  end

  always_comb begin
    grant_valid = req_pipe | req_ld;
    if (req_pipe && req_ld) begin
      grant = (last_q == REQ_LD) ? REQ_PIPE : REQ_LD;
    end else begin
      grant = req_ld ? REQ_LD : REQ_PIPE;
    end
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// Serializes 64-bit pipeline/loader accesses into little-endian byte beats on a
// single-port, synchronous-read byte memory.
module dm_access_ctrl
  import dm_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned BEATS  = DEF_BEATS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [63:0]       Address,
  input  logic [63:0]       DataWrite,
  output logic [63:0]       DataRead,
  output logic              MemStall,
  input  logic              LdReq,
  input  logic              LdWe,
  input  logic [63:0]       LdAddress,
  input  logic [63:0]       LdDataWrite,
  output logic [63:0]       LdDataRead,
  output logic              LdDone,
  output logic              AddrErr,
  output logic [ADDR_W-1:0] RamAddr,
  output logic [7:0]        RamWData,
  output logic              RamWe,
  output logic              RamRe,
  input  logic [7:0]        RamRData
);

  localparam int unsigned CntW = $clog2(BEATS);

  state_t              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                owner_q, store_q, err_q;
  logic [63:0]         wdata_q;
  logic [55:0]         rdata_q;
  logic [63:0]         data_read_q, ld_data_read_q;
  logic                ld_done_q, addr_err_q;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [7:0]          ram_wdata_q, ram_wdata_d;
  logic                ram_we_q, ram_we_d, ram_re_q, ram_re_d;

  logic                pipe_req, grant_valid, grant, arb_update;
  logic [63:0]         grant_addr, grant_wdata;
  logic                grant_store;

  assign pipe_req = MemRead | MemWrite;

  dm_rr_arbiter u_arb (
    .clk         (clk),
    .reset       (reset),
    .req_pipe    (pipe_req),
    .req_ld      (LdReq),
    .update      (arb_update),
    .served      (owner_q),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  // A pipeline request with both strobes set is treated as a store.
  assign grant_addr  = (grant == REQ_LD) ? LdAddress   : Address;
  assign grant_wdata = (grant == REQ_LD) ? LdDataWrite : DataWrite;
  assign grant_store = (grant == REQ_LD) ? LdWe        : MemWrite;

  // RAM strobes are registered one beat ahead so they line up with cnt_q.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;
    ram_re_d    = 1'b0;
    arb_update  = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d     = ACCESS;
          cnt_d       = '0;
          ram_addr_d  = grant_addr[ADDR_W-1:0];
          ram_wdata_d = get_byte(grant_wdata, 0);
          ram_we_d    = grant_store;
          ram_re_d    = ~grant_store;
        end
      end
      ACCESS: begin
        if (cnt_q == CntW'(BEATS - 1)) begin
          state_d = DRAIN;
        end else begin
          cnt_d       = cnt_q + CntW'(1);
          ram_addr_d  = ram_addr_q + ADDR_W'(1);
          ram_wdata_d = get_byte(wdata_q, 32'(cnt_q) + 32'd1);
          ram_we_d    = store_q;
          ram_re_d    = ~store_q;
        end
      end
      DRAIN: state_d = DONE;
      DONE: begin
        state_d    = IDLE;
        arb_update = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      owner_q        <= REQ_PIPE;
      store_q        <= 1'b0;
      err_q          <= 1'b0;
      wdata_q        <= '0;
      rdata_q        <= '0;
      data_read_q    <= '0;
      ld_data_read_q <= '0;
      ld_done_q      <= 1'b0;
      addr_err_q     <= 1'b0;
      ram_addr_q     <= '0;
      ram_wdata_q    <= '0;
      ram_we_q       <= 1'b0;
      ram_re_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
      ram_re_q    <= ram_re_d;
      ld_done_q   <= 1'b0;
      addr_err_q  <= 1'b0;
      if (state_q == IDLE && grant_valid) begin
        owner_q <= grant;
        store_q <= grant_store;
        wdata_q <= grant_wdata;
        err_q   <= |grant_addr[63:ADDR_W];
      end
      // RamRData carries the byte of the previous beat.
      if (state_q == ACCESS && cnt_q != '0) begin
        rdata_q[8*(32'(cnt_q) - 32'd1) +: 8] <= RamRData;
      end
      if (state_q == DRAIN) begin
        ld_done_q  <= (owner_q == REQ_LD);
        addr_err_q <= err_q;
        if (!store_q) begin
          if (owner_q == REQ_PIPE) begin
            data_read_q <= {RamRData, rdata_q};
          end else begin
            ld_data_read_q <= {RamRData, rdata_q};
          end
        end
      end
    end
  end

  assign MemStall   = pipe_req & ~(state_q == DONE && owner_q == REQ_PIPE);
  assign DataRead   = data_read_q;
  assign LdDataRead = ld_data_read_q;
  assign LdDone     = ld_done_q;
  assign AddrErr    = addr_err_q;
  assign RamAddr    = ram_addr_q;
  assign RamWData   = ram_wdata_q;
  assign RamWe      = ram_we_q;
  assign RamRe      = ram_re_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Bench for dm_access_ctrl: byte RAM, cycle-phase reference model, directed and random traffic.
module tb_dm_access_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemRead = 1'b0, MemWrite = 1'b0;
  logic [63:0] Address = '0, DataWrite = '0;
  logic [63:0] DataRead;
  logic        MemStall;
  logic        LdReq = 1'b0, LdWe = 1'b0;
  logic [63:0] LdAddress = '0, LdDataWrite = '0;
  logic [63:0] LdDataRead;
  logic        LdDone, AddrErr;
  logic [9:0]  RamAddr;
  logic [7:0]  RamWData;
  logic        RamWe, RamRe;
  logic [7:0]  RamRData = '0;

  dm_access_ctrl #(.ADDR_W(10), .BEATS(8)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite), .Address(Address),
    .DataWrite(DataWrite), .DataRead(DataRead), .MemStall(MemStall), .LdReq(LdReq),
    .LdWe(LdWe), .LdAddress(LdAddress), .LdDataWrite(LdDataWrite), .LdDataRead(LdDataRead),
    .LdDone(LdDone), .AddrErr(AddrErr), .RamAddr(RamAddr), .RamWData(RamWData),
    .RamWe(RamWe), .RamRe(RamRe), .RamRData(RamRData)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] init_byte(input int i);
    return 8'((i * 37 + 11) ^ (i >> 3));
  endfunction

  // Byte memory with synchronous read, as seen by the DUT.
  logic [7:0] tb_ram [0:1023];
  bit ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 1024; i++) tb_ram[i] <= init_byte(i);
      ram_init <= 1'b1;
    end else begin
      if (RamWe) tb_ram[RamAddr] <= RamWData;
      if (RamRe) RamRData <= tb_ram[RamAddr];
    end
  end

  // Reference model: an access occupies phases 1..10 after its sample cycle;
  // phases 1..8 carry byte k = phase-1, phase 10 is completion.
  logic [7:0]  ref_mem [0:1023];
  bit          m_started = 1'b0, m_active = 1'b0, m_owner = 1'b0, m_store = 1'b0;
  bit          m_err = 1'b0, m_last = 1'b1;
  int          m_ph = 0, m_addr = 0;
  logic [63:0] m_wdata = '0, exp_dr = '0, exp_ldr = '0, m_val;
  bit          m_p, m_l;

  always @(posedge clk) begin
    m_p = MemRead | MemWrite;
    m_l = LdReq;
    if (m_active && m_store && m_ph >= 1 && m_ph <= 8)
      ref_mem[(m_addr + m_ph - 1) % 1024] = m_wdata[8*(m_ph-1) +: 8];
    if (reset) begin
      if (!m_started) for (int i = 0; i < 1024; i++) ref_mem[i] = init_byte(i);
      m_started = 1'b1;
      m_active  = 1'b0;
      m_last    = 1'b1;
      exp_dr    = '0;
      exp_ldr   = '0;
    end else if (m_started) begin
      if (m_active) begin
        if (m_ph == 10) begin
          m_active = 1'b0;
          m_last   = m_owner;
        end else begin
          m_ph++;
          if (m_ph == 10 && !m_store) begin
            for (int i = 0; i < 8; i++) m_val[8*i +: 8] = ref_mem[(m_addr + i) % 1024];
            if (m_owner) exp_ldr = m_val;
            else exp_dr = m_val;
          end
        end
      end else if (m_p || m_l) begin
        m_owner = (m_p && m_l) ? !m_last : m_l;
        m_store = m_owner ? LdWe : MemWrite;
        m_addr  = m_owner ? int'(LdAddress[9:0]) : int'(Address[9:0]);
        m_wdata = m_owner ? LdDataWrite : DataWrite;
        m_err   = m_owner ? (LdAddress[63:10] != 0) : (Address[63:10] != 0);
        m_active = 1'b1;
        m_ph     = 1;
      end
    end
  end

  logic [9:0] addr_log [$];
  bit c_done, c_strobe;

  always @(negedge clk) begin
    if (m_started) begin
      c_done   = m_active && m_ph == 10;
      c_strobe = m_active && m_ph >= 1 && m_ph <= 8;
      chk("MemStall", MemStall, (MemRead | MemWrite) && !(c_done && !m_owner));
      chk("LdDone", LdDone, c_done && m_owner);
      chk("AddrErr", AddrErr, c_done && m_err);
      chk("RamWe", RamWe, c_strobe && m_store);
      chk("RamRe", RamRe, c_strobe && !m_store);
      if (c_strobe) chk("RamAddr", RamAddr, 64'((m_addr + m_ph - 1) % 1024));
      if (c_strobe && m_store) chk("RamWData", RamWData, m_wdata[8*(m_ph-1) +: 8]);
      chk("DataRead", DataRead, exp_dr);
      chk("LdDataRead", LdDataRead, exp_ldr);
      if (RamWe || RamRe) addr_log.push_back(RamAddr);
    end
  end

  // Drives one pipeline request from an idle cycle until MemStall falls.
  task automatic pipe_access(input logic rd, input logic wr, input logic [63:0] a,
                             input logic [63:0] d, output int n, output logic [63:0] dr,
                             output logic ae);
    MemRead = rd; MemWrite = wr; Address = a; DataWrite = d; n = 0;
    forever begin
      @(negedge clk);
      if (!MemStall) break;
      n++;
      if (n > 40) begin
        chk("pipe_timeout", 64'(n), 64'd10);
        break;
      end
    end
    dr = DataRead;
    ae = AddrErr;
    @(posedge clk); #1;
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  function automatic logic [63:0] rand_addr();
    int unsigned r = $urandom_range(0, 7);
    if (r == 0) return {$urandom, $urandom};
    if (r == 1) return 64'(1024 - $urandom_range(1, 8));
    return 64'($urandom_range(0, 1023));
  endfunction

  int          n, t0, pipe_t, ld_t;
  logic [63:0] dr, v;
  logic        ae, drop_p, drop_l, p_done, l_done;
  logic [7:0]  saved43;
  logic [1:0]  op;
  logic [9:0]  exp_a;

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Store then load a doubleword at 0x10.
    pipe_access(1'b0, 1'b1, 64'h10, 64'h8877665544332211, n, dr, ae);
    chk("st_stall_cycles", 64'(n), 64'd10);
    for (int i = 0; i < 8; i++) chk("st_ram_byte", tb_ram[16 + i], 64'(8'h11 * (i + 1)));
    pipe_access(1'b1, 1'b0, 64'h10, 64'h0, n, dr, ae);
    chk("ld_stall_cycles", 64'(n), 64'd10);
    chk("ld_data", dr, 64'h8877665544332211);
    chk("ld_model_data", exp_dr, 64'h8877665544332211);

    // Read+write together: store wins, DataRead keeps prior value.
    pipe_access(1'b1, 1'b1, 64'h20, '1, n, dr, ae);
    chk("rw_keep_data", dr, 64'h8877665544332211);
    for (int i = 0; i < 8; i++) chk("rw_ram_byte", tb_ram[32 + i], 64'hFF);

    // Wrap past the top of memory.
    addr_log.delete();
    pipe_access(1'b1, 1'b0, 64'h3FC, 64'h0, n, dr, ae);
    chk("wrap_beats", 64'(addr_log.size()), 64'd8);
    for (int i = 0; i < 8 && i < addr_log.size(); i++) begin
      exp_a = 10'h3FC + 10'(i);
      chk("wrap_addr", addr_log[i], exp_a);
    end
    chk("wrap_addrerr", ae, 1'b0);

    // Out-of-range address.
    addr_log.delete();
    pipe_access(1'b1, 1'b0, 64'h400, 64'h0, n, dr, ae);
    chk("oor_first_addr", addr_log.size() > 0 ? addr_log[0] : 10'h3FF, 10'h000);
    chk("oor_addrerr", ae, 1'b1);

    // Tie right after reset: pipeline first, loader next.
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    MemRead = 1'b1; Address = 64'h10;
    LdReq = 1'b1; LdWe = 1'b0; LdAddress = 64'h10;
    t0 = cyc; pipe_t = -1; ld_t = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      drop_p = MemRead && !MemStall;
      drop_l = LdDone;
      if (drop_p) pipe_t = cyc - t0;
      if (drop_l) begin
        ld_t = cyc - t0;
        chk("tie_ld_data", LdDataRead, 64'h8877665544332211);
      end
      @(posedge clk); #1;
      if (drop_p) MemRead = 1'b0;
      if (drop_l) begin
        LdReq = 1'b0;
        break;
      end
    end
    LdReq = 1'b0; MemRead = 1'b0;
    chk("tie_pipe_done_cycle", 64'(pipe_t), 64'd10);
    chk("tie_ld_done_cycle", 64'(ld_t), 64'd21);

    // Reset during a store: bytes of cycles 1..3 land, nothing after.
    saved43 = tb_ram[10'h43];
    v = {32'h0D0C0B0A, ~saved43, 24'hC3B2A1};
    MemWrite = 1'b1; Address = 64'h40; DataWrite = v;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0; MemWrite = 1'b0;
    @(negedge clk);
    chk("rst_ramwe", RamWe, 1'b0);
    chk("rst_ramre", RamRe, 1'b0);
    chk("rst_ramaddr", RamAddr, 10'h0);
    chk("rst_ramwdata", RamWData, 8'h0);
    chk("rst_lddone", LdDone, 1'b0);
    chk("rst_addrerr", AddrErr, 1'b0);
    chk("rst_dataread", DataRead, 64'h0);
    chk("rst_lddataread", LdDataRead, 64'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_byte40", tb_ram[10'h40], 8'hA1);
    chk("abort_byte41", tb_ram[10'h41], 8'hB2);
    chk("abort_byte42", tb_ram[10'h42], 8'hC3);
    chk("abort_byte43", tb_ram[10'h43], saved43);
    pipe_access(1'b1, 1'b0, 64'h40, 64'h0, n, dr, ae);
    chk("post_rst_stall", 64'(n), 64'd10);
    chk("post_rst_low3", dr[23:0], 24'hC3B2A1);

    // Random traffic on both ports with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      p_done = (MemRead | MemWrite) && !MemStall;
      l_done = LdDone;
      @(posedge clk); #1;
      reset = ($urandom_range(0, 299) == 0);
      if (p_done) begin MemRead = 1'b0; MemWrite = 1'b0; end
      if (l_done) LdReq = 1'b0;
      if (!(MemRead | MemWrite) && $urandom_range(0, 2) == 0) begin
        op = 2'($urandom_range(1, 3));
        MemRead = op[0]; MemWrite = op[1];
        Address = rand_addr(); DataWrite = {$urandom, $urandom};
      end
      if (!LdReq && $urandom_range(0, 2) == 0) begin
        LdReq = 1'b1; LdWe = 1'($urandom_range(0, 1));
        LdAddress = rand_addr(); LdDataWrite = {$urandom, $urandom};
      end
    end
    reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; LdReq = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
